// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single fixed-latency memory.
// Data port has priority; a starvation counter hands the memory to fetch after STARVE_LIM data grants.
module mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned STV_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_e;
  typedef enum logic {PORT_IF = 1'b0, PORT_DM = 1'b1} port_e;

  state_e            state_q, state_d;
  port_e             owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [DW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     dm_rdata_q, dm_rdata_d;

  logic if_cand, dm_cand, starved, grant_if, grant_dm;

  // The port being acknowledged in RESP still holds req high, so it sits out this decision.
  assign if_cand  = if_req & ~((state_q == S_RESP) & (owner_q == PORT_IF));
  assign dm_cand  = dm_req & ~((state_q == S_RESP) & (owner_q == PORT_DM));
  assign starved  = if_cand & (starve_q == STV_W'(STARVE_LIM));
  assign grant_dm = dm_cand & ~starved;
  assign grant_if = if_cand & ~grant_dm;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    case (state_q)
      S_ACCESS: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
          if (owner_q == PORT_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d       = cnt_q - CNT_W'(1);
          mem_en_d    = 1'b1;
          mem_we_d    = mem_we_q;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end
      default: begin
        // IDLE and RESP share the grant decision; RESP falls back to IDLE when nothing is granted.
        state_d = S_IDLE;
        if (grant_if || grant_dm) begin
          state_d  = S_ACCESS;
          cnt_d    = CNT_W'(MEM_LAT);
          mem_en_d = 1'b1;
          if (grant_dm) begin
            owner_d     = PORT_DM;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (!if_cand)                               starve_d = '0;
            else if (starve_q != STV_W'(STARVE_LIM))    starve_d = starve_q + STV_W'(1);
          end else begin
            owner_d    = PORT_IF;
            mem_addr_d = if_addr;
            starve_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= PORT_IF;
      cnt_q       <= '0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_LIM = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ready, dm_req, dm_we, dm_ready, mem_en, mem_we, stall_if, stall_mem;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        i_dm_req;
    logic        i_dm_we;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic [31:0] i_mem_rdata;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_if_ready;
    logic [31:0] e_if_rdata;
    logic        e_dm_ready;
    logic [31:0] e_dm_rdata;
    logic        e_stall_if;
    logic        e_stall_mem;
  } vec_t;

  vec_t vt[15];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mr,
                              input logic een, input logic ewe, input logic [31:0] eaddr,
                              input logic [31:0] ewd, input logic eir, input logic [31:0] eird,
                              input logic edr, input logic [31:0] edrd, input logic esi, input logic esm);
    vec_t v;
    v.i_if_req = ir;  v.i_if_addr = ia;  v.i_dm_req = dr; v.i_dm_we = dw;
    v.i_dm_addr = da; v.i_dm_wdata = dwd; v.i_mem_rdata = mr;
    v.e_mem_en = een; v.e_mem_we = ewe; v.e_mem_addr = eaddr; v.e_mem_wdata = ewd;
    v.e_if_ready = eir; v.e_if_rdata = eird; v.e_dm_ready = edr; v.e_dm_rdata = edrd;
    v.e_stall_if = esi; v.e_stall_mem = esm;
    return v;
  endfunction

  task automatic apply_row(input vec_t v, input int i);
    if_req = v.i_if_req; if_addr = v.i_if_addr; dm_req = v.i_dm_req; dm_we = v.i_dm_we;
    dm_addr = v.i_dm_addr; dm_wdata = v.i_dm_wdata; mem_rdata = v.i_mem_rdata;
    #1;
    cmp($sformatf("row%0d mem_en", i),    32'(mem_en),    32'(v.e_mem_en));
    cmp($sformatf("row%0d mem_we", i),    32'(mem_we),    32'(v.e_mem_we));
    cmp($sformatf("row%0d mem_addr", i),  mem_addr,       v.e_mem_addr);
    cmp($sformatf("row%0d mem_wdata", i), mem_wdata,      v.e_mem_wdata);
    cmp($sformatf("row%0d if_ready", i),  32'(if_ready),  32'(v.e_if_ready));
    cmp($sformatf("row%0d if_rdata", i),  if_rdata,       v.e_if_rdata);
    cmp($sformatf("row%0d dm_ready", i),  32'(dm_ready),  32'(v.e_dm_ready));
    cmp($sformatf("row%0d dm_rdata", i),  dm_rdata,       v.e_dm_rdata);
    cmp($sformatf("row%0d stall_if", i),  32'(stall_if),  32'(v.e_stall_if));
    cmp($sformatf("row%0d stall_mem", i), 32'(stall_mem), 32'(v.e_stall_mem));
  endtask

  // Reference model: one outstanding transaction with a count of cycles left (access cycles + ack).
  int          m_rem;
  logic        m_own_dm, m_we;
  int          m_starve;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

  task automatic model_reset();
    m_rem = 0; m_own_dm = 1'b0; m_we = 1'b0; m_starve = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
  endtask

  task automatic model_edge();
    logic c_if, c_dm, take_dm;
    if (m_rem > 1) begin
      if (m_rem == 2 && !m_we) begin
        if (m_own_dm) m_dm_rdata = mem_rdata;
        else          m_if_rdata = mem_rdata;
      end
      m_rem--;
    end else begin
      c_if  = if_req && !(m_rem == 1 && !m_own_dm);
      c_dm  = dm_req && !(m_rem == 1 && m_own_dm);
      m_rem = 0;
      if (c_if || c_dm) begin
        take_dm = c_dm && !(c_if && m_starve == int'(STARVE_LIM));
        if (take_dm && c_if) m_starve = (m_starve < int'(STARVE_LIM)) ? m_starve + 1 : m_starve;
        else                 m_starve = 0;
        m_own_dm = take_dm;
        m_we     = take_dm && dm_we;
        m_addr   = take_dm ? dm_addr : if_addr;
        m_wdata  = take_dm ? dm_wdata : 32'h0;
        m_rem    = int'(MEM_LAT) + 1;
      end
    end
  endtask

  task automatic model_check(input int cyc);
    logic acc, e_ifr, e_dmr;
    acc   = (m_rem > 1);
    e_ifr = (m_rem == 1) && !m_own_dm;
    e_dmr = (m_rem == 1) && m_own_dm;
    cmp($sformatf("rnd%0d mem_en", cyc),    32'(mem_en),    32'(acc));
    cmp($sformatf("rnd%0d mem_we", cyc),    32'(mem_we),    32'(acc && m_we));
    cmp($sformatf("rnd%0d mem_addr", cyc),  mem_addr,       acc ? m_addr : 32'h0);
    cmp($sformatf("rnd%0d mem_wdata", cyc), mem_wdata,      acc ? m_wdata : 32'h0);
    cmp($sformatf("rnd%0d if_ready", cyc),  32'(if_ready),  32'(e_ifr));
    cmp($sformatf("rnd%0d dm_ready", cyc),  32'(dm_ready),  32'(e_dmr));
    cmp($sformatf("rnd%0d if_rdata", cyc),  if_rdata,       m_if_rdata);
    cmp($sformatf("rnd%0d dm_rdata", cyc),  dm_rdata,       m_dm_rdata);
    cmp($sformatf("rnd%0d stall_if", cyc),  32'(stall_if),  32'(if_req && !e_ifr));
    cmp($sformatf("rnd%0d stall_mem", cyc), 32'(stall_mem), 32'(dm_req && !e_dmr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int          dm_first, if_first, ngr, dm_done, n_dm, n_if, bad, lat;
    logic        drop_dm, drop_if, dm_ack, if_ack, prev_en;
    logic [7:0]  gr_dm, exp_gr;
    logic [31:0] lat_rdata;

    // Fetch 0x40, then a load (sets dm_rdata), then a store that must leave dm_rdata alone.
    vt[0]  = mk(1, 32'h40, 0, 0, 0, 0, 32'h0,        0, 0, 0,      0,            0, 0,            0, 0,            1, 0);
    vt[1]  = mk(1, 32'h40, 0, 0, 0, 0, 32'h11111111, 1, 0, 32'h40, 0,            0, 0,            0, 0,            1, 0);
    vt[2]  = mk(1, 32'h40, 0, 0, 0, 0, 32'h8C020004, 1, 0, 32'h40, 0,            0, 0,            0, 0,            1, 0);
    vt[3]  = mk(1, 32'h40, 0, 0, 0, 0, 32'h0,        0, 0, 0,      0,            1, 32'h8C020004, 0, 0,            0, 0);
    vt[4]  = mk(0, 32'h0,  0, 0, 0, 0, 32'h0,        0, 0, 0,      0,            0, 32'h8C020004, 0, 0,            0, 0);
    vt[5]  = mk(0, 32'h0,  1, 0, 32'h100, 0, 32'h0,        0, 0, 0,       0,     0, 32'h8C020004, 0, 0,            0, 1);
    vt[6]  = mk(0, 32'h0,  1, 0, 32'h100, 0, 32'h22222222, 1, 0, 32'h100, 0,     0, 32'h8C020004, 0, 0,            0, 1);
    vt[7]  = mk(0, 32'h0,  1, 0, 32'h100, 0, 32'h12345678, 1, 0, 32'h100, 0,     0, 32'h8C020004, 0, 0,            0, 1);
    vt[8]  = mk(0, 32'h0,  1, 0, 32'h100, 0, 32'h0,        0, 0, 0,       0,     0, 32'h8C020004, 1, 32'h12345678, 0, 0);
    vt[9]  = mk(0, 32'h0,  0, 0, 32'h0,   0, 32'h0,        0, 0, 0,       0,     0, 32'h8C020004, 0, 32'h12345678, 0, 0);
    vt[10] = mk(0, 32'h0,  1, 1, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0,     0,            0, 32'h8C020004, 0, 32'h12345678, 0, 1);
    vt[11] = mk(0, 32'h0,  1, 1, 32'h10, 32'hDEADBEEF, 32'hAAAAAAAA, 1, 1, 32'h10, 32'hDEADBEEF, 0, 32'h8C020004, 0, 32'h12345678, 0, 1);
    vt[12] = mk(0, 32'h0,  1, 1, 32'h10, 32'hDEADBEEF, 32'hBBBBBBBB, 1, 1, 32'h10, 32'hDEADBEEF, 0, 32'h8C020004, 0, 32'h12345678, 0, 1);
    vt[13] = mk(0, 32'h0,  1, 1, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 0,     0,            0, 32'h8C020004, 1, 32'h12345678, 0, 0);
    vt[14] = mk(0, 32'h0,  0, 0, 32'h0,  32'h0,        32'h0,        0, 0, 0,     0,            0, 32'h8C020004, 0, 32'h12345678, 0, 0);

    reset = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset mem_en", 32'(mem_en), 32'h0);
    cmp("reset mem_addr", mem_addr, 32'h0);
    cmp("reset if_ready", 32'(if_ready), 32'h0);
    cmp("reset dm_ready", 32'(dm_ready), 32'h0);
    cmp("reset if_rdata", if_rdata, 32'h0);
    cmp("reset dm_rdata", dm_rdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      apply_row(vt[i], i);
      step();
    end

    // Collision: both ports request together; data first, fetch handed over from RESP.
    if_req = 1; if_addr = 32'h200; dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_wdata = 0;
    dm_first = -1; if_first = -1; drop_dm = 0; drop_if = 0;
    for (int k = 0; k < 12; k++) begin
      if (drop_dm) dm_req = 0;
      if (drop_if) if_req = 0;
      mem_rdata = 32'hC0FFEE00 + 32'(k);
      #1;
      if (dm_ready) begin if (dm_first < 0) dm_first = k; drop_dm = 1; end
      if (if_ready) begin if (if_first < 0) if_first = k; drop_if = 1; end
      if (k == 1) cmp("collision first access addr", mem_addr, 32'h100);
      if (k == 4) cmp("collision second access addr", mem_addr, 32'h200);
      step();
    end
    cmp("collision dm_ready cycle", 32'(dm_first), 32'd3);
    cmp("collision if_ready cycle", 32'(if_first), 32'd6);
    cmp("collision dm_rdata", dm_rdata, 32'hC0FFEE02);
    cmp("collision if_rdata", if_rdata, 32'hC0FFEE05);

    // Fetch held high with four back-to-back loads: every RESP hands the memory to the other port.
    if_req = 1; if_addr = 32'h400; dm_req = 1; dm_we = 0; dm_addr = 32'h800;
    ngr = 0; dm_done = 0; gr_dm = '0; exp_gr = 8'h55; prev_en = 0; dm_ack = 0; if_ack = 0;
    for (int k = 0; k < 40; k++) begin
      if (dm_ack) begin
        dm_ack = 0; dm_done++;
        if (dm_done < 4) dm_addr = 32'h800 + 32'(4 * dm_done);
        else             dm_req = 0;
      end
      if (if_ack) begin
        if_ack = 0;
        if (dm_done < 4) if_addr = if_addr + 32'd4;
        else             if_req = 0;
      end
      mem_rdata = $urandom;
      #1;
      if (mem_en && !prev_en) begin
        if (ngr < 8) gr_dm[ngr] = (mem_addr >= 32'h800);
        ngr++;
      end
      prev_en = mem_en;
      if (dm_ready) dm_ack = 1;
      if (if_ready) if_ack = 1;
      step();
    end
    cmp("interleave grant count", 32'(ngr), 32'd8);
    for (int i = 0; i < 8; i++) cmp($sformatf("interleave grant%0d is data", i), 32'(gr_dm[i]), 32'(exp_gr[i]));
    if_req = 0; dm_req = 0;

    // A data request raised and dropped while fetch owns the memory is never served.
    if_req = 1; if_addr = 32'h40; n_dm = 0; n_if = 0; bad = 0; if_ack = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) begin dm_req = 1; dm_we = 0; dm_addr = 32'h900; end
      if (k == 2) dm_req = 0;
      if (if_ack) if_req = 0;
      #1;
      if (dm_ready) n_dm++;
      if (mem_en && mem_addr == 32'h900) bad++;
      if (if_ready) begin n_if++; if_ack = 1; end
      step();
    end
    cmp("dropped dm_ready count", 32'(n_dm), 32'd0);
    cmp("dropped dm access count", 32'(bad), 32'd0);
    cmp("dropped-case if_ready count", 32'(n_if), 32'd1);

    // Reset during the second access cycle of a fetch.
    if_req = 1; if_addr = 32'h80; mem_rdata = 32'h77777777;
    step();
    step();
    cmp("pre-reset mem_en", 32'(mem_en), 32'h1);
    reset = 1'b1;
    #1;
    cmp("midreset mem_en", 32'(mem_en), 32'h0);
    cmp("midreset mem_addr", mem_addr, 32'h0);
    cmp("midreset if_ready", 32'(if_ready), 32'h0);
    cmp("midreset if_rdata", if_rdata, 32'h0);
    cmp("midreset dm_rdata", dm_rdata, 32'h0);
    cmp("midreset stall_if", 32'(stall_if), 32'h1);
    n_if = 0;
    repeat (2) begin
      step();
      if (if_ready) n_if++;
    end
    cmp("midreset no if_ready", 32'(n_if), 32'd0);
    reset = 1'b0;
    lat = -1; lat_rdata = '0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (if_ready && lat < 0) begin lat = k; lat_rdata = if_rdata; end
      step();
    end
    cmp("post-reset fetch latency", 32'(lat), 32'(MEM_LAT + 1));
    cmp("post-reset fetch data", lat_rdata, 32'h77777777);
    if_req = 0;

    // Randomized traffic against the reference model.
    reset = 1'b1; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; if_addr = 0;
    step();
    step();
    reset = 1'b0;
    model_reset();
    if_ack = 0; dm_ack = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (if_ack) begin
        if_ack = 0;
        if ($urandom_range(1, 0) == 1) if_addr = $urandom;
        else                           if_req = 0;
      end else if (!if_req && $urandom_range(9, 0) < 4) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_ack) begin
        dm_ack = 0;
        if ($urandom_range(1, 0) == 1) begin
          dm_we = 1'($urandom_range(1, 0)); dm_addr = $urandom; dm_wdata = $urandom;
        end else dm_req = 0;
      end else if (!dm_req && $urandom_range(9, 0) < 4) begin
        dm_req = 1; dm_we = 1'($urandom_range(1, 0)); dm_addr = $urandom; dm_wdata = $urandom;
      end
      mem_rdata = $urandom;
      #1;
      model_check(cyc);
      if (if_ready) if_ack = 1;
      if (dm_ready) dm_ack = 1;
      model_edge();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
